hazard_scoreboard: RTL and testbench

Parametrised data-hazard unit for pipelines of configurable depth with per-instruction result latency (ALU, load, multi-cycle multiply). It tracks every in-flight writer in a shift register that mirrors the pipeline from EX to WB. It sits beside the decode stage and drives the decode stall and the per-operand EX forwarding selects. It also honours a global pipeline hold and an EX-stage kill.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bundle: ID operands/destination and hold/kill in; stall and EX forwarding selects out.
// Combinational outputs with no handshake; hold freezes the tracked pipeline and stall back-pressures ID/IF.
interface hazard_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int STAGE_W = 2
);
    logic               hold;
    logic               issue_valid;
    logic [ADDR_W-1:0]  issue_rd;
    logic [STAGE_W-1:0] issue_ready_stage;
    logic [ADDR_W-1:0]  rs1;
    logic [ADDR_W-1:0]  rs2;
    logic               rs1_used;
    logic               rs2_used;
    logic               kill_ex;
    logic               stall;
    logic [STAGE_W-1:0] fwd1;
    logic [STAGE_W-1:0] fwd2;
    logic [31:0]        stall_count;

    modport master (
        output hold, issue_valid, issue_rd, issue_ready_stage,
        output rs1, rs2, rs1_used, rs2_used, kill_ex,
        input  stall, fwd1, fwd2, stall_count
    );

    modport slave (
        input  hold, issue_valid, issue_rd, issue_ready_stage,
        input  rs1, rs2, rs1_used, rs2_used, kill_ex,
        output stall, fwd1, fwd2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard tracking in-flight writers EX..WB; stall/fwd are zero-latency from state.
// Stall back-pressures ID/IF; hold freezes all entries. Optional stall counter under HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int ADDR_W  = 5,
    parameter int STAGE_W = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              reset_n,
    hazard_scoreboard_if.slave sb
);
    // The WB entry is never consulted (register file is write-first), so only EX..DEPTH-1 is stored.
    localparam int LAST = DEPTH - 1;

    logic [LAST:1]      vld_q, vld_d;
    logic [ADDR_W-1:0]  rd_q  [1:LAST];
    logic [ADDR_W-1:0]  rd_d  [1:LAST];
    logic [STAGE_W-1:0] rdy_q [1:LAST];
    logic [STAGE_W-1:0] rdy_d [1:LAST];

    logic               hit1, hit2, haz1, haz2, stall;
    logic [STAGE_W-1:0] k1, k2, rdy1, rdy2;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        k1   = '0;
        k2   = '0;
        rdy1 = '0;
        rdy2 = '0;
        // Scan oldest to youngest so the youngest match overwrites older ones.
        for (int k = LAST; k >= 1; k--) begin
            if (vld_q[k] && rd_q[k] == sb.rs1 && sb.rs1 != '0 && sb.rs1_used) begin
                hit1 = 1'b1;
                k1   = STAGE_W'(k);
                rdy1 = rdy_q[k];
            end
            if (vld_q[k] && rd_q[k] == sb.rs2 && sb.rs2 != '0 && sb.rs2_used) begin
                hit2 = 1'b1;
                k2   = STAGE_W'(k);
                rdy2 = rdy_q[k];
            end
        end
        haz1  = hit1 && (rdy1 > k1);
        haz2  = hit2 && (rdy2 > k2);
        stall = sb.issue_valid && (haz1 || haz2);
    end

    assign sb.stall = stall;
    assign sb.fwd1  = (hit1 && !haz1 && !stall) ? STAGE_W'(k1 + 1'b1) : '0;
    assign sb.fwd2  = (hit2 && !haz2 && !stall) ? STAGE_W'(k2 + 1'b1) : '0;

    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        rdy_d = rdy_q;
        if (!sb.hold) begin
            for (int k = LAST; k >= 2; k--) begin
                vld_d[k] = vld_q[k-1] && !(k == 2 && sb.kill_ex);
                rd_d[k]  = rd_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            vld_d[1] = sb.issue_valid && !stall && sb.issue_rd != '0 && sb.issue_ready_stage != '0;
            rd_d[1]  = sb.issue_rd;
            rdy_d[1] = sb.issue_ready_stage;
        end else if (sb.kill_ex) begin
            vld_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 1; k <= LAST; k++) begin
                rd_q[k]  <= '0;
                rdy_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            rdy_q <= rdy_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !sb.hold && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign sb.stall_count = stall_cnt_q;
`else
    assign sb.stall_count = '0;
`endif

    a_ready_stage_legal: assert property (@(posedge clk) disable iff (!reset_n)
        !(sb.issue_valid && int'(sb.issue_ready_stage) > DEPTH));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at DEPTH=3 and DEPTH=5; stall_count expectations follow HAZARD_STATS_EN.
module tb_hazard_scoreboard;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.ADDR_W(5), .STAGE_W(2)) b3 ();
    hazard_scoreboard_if #(.ADDR_W(5), .STAGE_W(3)) b5 ();

    hazard_scoreboard #(.DEPTH(3), .ADDR_W(5), .STAGE_W(2)) u_d3 (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (b3)
    );

    hazard_scoreboard #(.DEPTH(5), .ADDR_W(5), .STAGE_W(3)) u_d5 (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (b5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sc(input int n);
`ifdef HAZARD_STATS_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic drv3(input logic v, input logic [4:0] rd, input logic [1:0] rdy,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        input logic h, input logic k);
        b3.issue_valid       = v;
        b3.issue_rd          = rd;
        b3.issue_ready_stage = rdy;
        b3.rs1               = r1;
        b3.rs1_used          = u1;
        b3.rs2               = r2;
        b3.rs2_used          = u2;
        b3.hold              = h;
        b3.kill_ex           = k;
    endtask

    task automatic drv5(input logic v, input logic [4:0] rd, input logic [2:0] rdy,
                        input logic [4:0] r1, input logic u1);
        b5.issue_valid       = v;
        b5.issue_rd          = rd;
        b5.issue_ready_stage = rdy;
        b5.rs1               = r1;
        b5.rs1_used          = u1;
        b5.rs2               = 5'd0;
        b5.rs2_used          = 1'b0;
        b5.hold              = 1'b0;
        b5.kill_ex           = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush3();
        drv3(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drv3(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv5(0, 0, 0, 0, 0);
        #12;
        chk("rst_stall", 32'(b3.stall), 0);
        chk("rst_fwd1", 32'(b3.fwd1), 0);
        chk("rst_fwd2", 32'(b3.fwd2), 0);
        chk("rst_cnt", b3.stall_count, 0);
        chk("rst_stall5", 32'(b5.stall), 0);
        reset_n = 1'b1;
        cyc();

        // ALU producer, consumer directly behind then one further back
        drv3(1, 5, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("alu_prod_stall", 32'(b3.stall), 0);
        cyc();
        drv3(1, 0, 0, 5, 1, 0, 0, 0, 0); #1;
        chk("alu_stall", 32'(b3.stall), 0);
        chk("alu_fwd1_e1", 32'(b3.fwd1), 2);
        cyc();
        #1;
        chk("alu_fwd1_e2", 32'(b3.fwd1), 3);
        cyc();
        flush3();

        // Load-use: one stall cycle on rs2, then forward from stage 2
        drv3(1, 7, 2, 0, 0, 0, 0, 0, 0);
        cyc();
        drv3(1, 0, 0, 0, 0, 7, 1, 0, 0); #1;
        chk("ld_stall", 32'(b3.stall), 1);
        chk("ld_fwd2_stalled", 32'(b3.fwd2), 0);
        cyc();
        #1;
        chk("ld_stall_done", 32'(b3.stall), 0);
        chk("ld_fwd2", 32'(b3.fwd2), 3);
        cyc();
        chk("ld_cnt", b3.stall_count, sc(1));
        flush3();

        // Two writers of r3: youngest wins; r0 never matches
        drv3(1, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        drv3(1, 0, 0, 3, 1, 0, 0, 0, 0); #1;
        chk("young_fwd1", 32'(b3.fwd1), 2);
        chk("young_stall", 32'(b3.stall), 0);
        cyc();
        flush3();
        drv3(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        drv3(1, 0, 0, 0, 1, 0, 0, 0, 0); #1;
        chk("r0_fwd1", 32'(b3.fwd1), 0);
        chk("r0_stall", 32'(b3.stall), 0);
        cyc();
        flush3();

        // Hazard present but ID slot invalid: no stall, no forward
        drv3(1, 7, 2, 0, 0, 0, 0, 0, 0);
        cyc();
        drv3(0, 0, 0, 0, 0, 7, 1, 0, 0); #1;
        chk("inv_stall", 32'(b3.stall), 0);
        chk("inv_fwd2", 32'(b3.fwd2), 0);
        cyc();
        flush3();

        // Load held in EX for 3 cycles, then one real stall cycle
        drv3(1, 9, 2, 0, 0, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drv3(1, 0, 0, 9, 1, 0, 0, 1, 0); #1;
            chk("hold_stall", 32'(b3.stall), 1);
            cyc();
        end
        chk("hold_cnt", b3.stall_count, sc(1));
        drv3(1, 0, 0, 9, 1, 0, 0, 0, 0); #1;
        chk("hold_rel_stall", 32'(b3.stall), 1);
        cyc();
        #1;
        chk("hold_rel_done", 32'(b3.stall), 0);
        chk("hold_fwd1", 32'(b3.fwd1), 3);
        cyc();
        chk("hold_rel_cnt", b3.stall_count, sc(2));
        flush3();

        // Kill the load in EX while a new ALU writer issues
        drv3(1, 4, 2, 0, 0, 0, 0, 0, 0);
        cyc();
        drv3(1, 8, 1, 0, 0, 0, 0, 0, 1); #1;
        chk("kill_iss_stall", 32'(b3.stall), 0);
        cyc();
        drv3(1, 0, 0, 4, 1, 8, 1, 0, 0); #1;
        chk("kill_stall", 32'(b3.stall), 0);
        chk("kill_fwd1", 32'(b3.fwd1), 0);
        chk("kill_new_fwd2", 32'(b3.fwd2), 2);
        cyc();
        flush3();

        // Kill under hold clears EX in place
        drv3(1, 11, 2, 0, 0, 0, 0, 0, 0);
        cyc();
        drv3(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc();
        drv3(1, 0, 0, 11, 1, 0, 0, 0, 0); #1;
        chk("hkill_stall", 32'(b3.stall), 0);
        chk("hkill_fwd1", 32'(b3.fwd1), 0);
        cyc();
        flush3();
        chk("d3_final_cnt", b3.stall_count, sc(2));

        // DEPTH=5 multiply with ready=4: three stall cycles, then forward from stage 4
        drv5(1, 6, 4, 0, 0);
        cyc();
        drv5(1, 0, 0, 6, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mul_stall", 32'(b5.stall), 1);
            chk("mul_fwd1_stalled", 32'(b5.fwd1), 0);
            cyc();
        end
        #1;
        chk("mul_stall_done", 32'(b5.stall), 0);
        chk("mul_fwd1", 32'(b5.fwd1), 5);
        cyc();
        chk("mul_cnt", b5.stall_count, sc(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
